// File: rtl/xor_share_arb.sv
// Round-robin arbiter that shares one registered XOR unit between N_REQ requesters.
// Winner is picked in IDLE, computed in CALC, and reported with a one-cycle gnt/y_valid pulse.
module xor_share_arb #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_bus,
    input  logic [N_REQ*WIDTH-1:0] b_bus,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       y,
    output logic                   y_valid,
    output logic [IDW-1:0]         y_id,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t state, state_nxt;

    logic [N_REQ-1:0][WIDTH-1:0] a_arr, b_arr;
    logic [WIDTH-1:0]            a_lat, b_lat;
    logic [IDW-1:0]              last_winner, win_id, rr_id;
    logic                        rr_found;
    logic [IDW:0]                idx;

    assign a_arr = a_bus;
    assign b_arr = b_bus;
    assign busy  = (state == CALC) || (state == RESP);

    // Scan starts one past the last winner and wraps, so the last winner ends up lowest priority.
    always_comb begin
        rr_found = 1'b0;
        rr_id    = '0;
        idx      = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = {1'b0, last_winner} + (IDW+1)'(off);
            if (idx >= (IDW+1)'(N_REQ))
                idx = idx - (IDW+1)'(N_REQ);
            if (!rr_found && req[idx[IDW-1:0]]) begin
                rr_found = 1'b1;
                rr_id    = idx[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rr_found) state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result pulse is registered on the RESP edge, so gnt/y_valid appear one cycle after RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt         <= '0;
            y           <= '0;
            y_valid     <= 1'b0;
            y_id        <= '0;
            a_lat       <= '0;
            b_lat       <= '0;
            win_id      <= '0;
            last_winner <= IDW'(N_REQ - 1);
        end else begin
            gnt     <= '0;
            y_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rr_found) begin
                        a_lat  <= a_arr[rr_id];
                        b_lat  <= b_arr[rr_id];
                        win_id <= rr_id;
                    end
                end
                CALC: y <= a_lat ^ b_lat;
                RESP: begin
                    y_valid     <= 1'b1;
                    gnt         <= N_REQ'(1) << win_id;
                    y_id        <= win_id;
                    last_winner <= win_id;
                end
                default: ;
            endcase
        end
    end

endmodule
